sa_tile_controller: RTL and testbench

- Next-generation systolic-array sequencer; replaces the fixed 4-state ROWS/COLS controller.
- Runs a programmable number of output tiles per command, each with a run-time reduction depth k_len.
- Adds an explicit pipeline-drain phase, store backpressure, busy/done handshake and per-tile indexing.
- Sits between the host command interface and the PE array, input loaders and output store unit.

---
 rtl/sa_tile_controller_pkg.sv | 18 +
 rtl/sa_tile_controller_if.sv | 46 ++++
 rtl/sa_tile_controller_phase_counter.sv | 26 ++
 rtl/sa_tile_controller.sv | 145 ++++++++++++++
 tb/tb_sa_tile_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sa_tile_controller_pkg.sv
// State encoding and phase-length helpers shared by the systolic-array tile sequencer.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_MAC    = 3'd2,
        S_DRAIN  = 3'd3,
        S_STORE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Skew flush: the last operand needs ROWS+COLS-2 extra cycles to reach the far PE.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

endpackage

// File: rtl/sa_tile_controller_if.sv
// Command/status/store bundle of the tile sequencer. Optional abort input under SA_TILE_CTRL_ABORT_EN.
interface sa_tile_controller_if #(
    parameter int K_MAX   = 16,
    parameter int TILE_W  = 8,
    parameter int CYCLE_W = 5
);
    localparam int KW = $clog2(K_MAX + 1);

    logic               start;
    logic [KW-1:0]      k_len;
    logic [TILE_W-1:0]  num_tiles;
    logic               store_ready;
`ifdef SA_TILE_CTRL_ABORT_EN
    logic               abort;
`endif
    logic               busy;
    logic               done;
    logic               cmd_err;
    logic [2:0]         global_state;
    logic [CYCLE_W-1:0] cycle;
    logic [TILE_W-1:0]  tile_idx;
    logic               load_en;
    logic               mac_en;
    logic               store_en;

    // Store handshake: a row transfers on a cycle where store_en and store_ready are both high;
    // store_en already includes store_ready, so the store unit may treat store_en alone as the strobe.
    modport master (
`ifdef SA_TILE_CTRL_ABORT_EN
        output abort,
`endif
        output start, k_len, num_tiles, store_ready,
        input  busy, done, cmd_err, global_state, cycle, tile_idx,
        input  load_en, mac_en, store_en
    );

    modport slave (
`ifdef SA_TILE_CTRL_ABORT_EN
        input  abort,
`endif
        input  start, k_len, num_tiles, store_ready,
        output busy, done, cmd_err, global_state, cycle, tile_idx,
        output load_en, mac_en, store_en
    );

endinterface

// File: rtl/sa_tile_controller_phase_counter.sv
// In-state cycle counter: cleared on state entry, advanced by en, flags the final cycle of a phase.
module sa_phase_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] len,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign last = (count == (len - W'(1)));

endmodule

// File: rtl/sa_tile_controller.sv
// Tile sequencer: load X, MAC over k_len, drain skew, store ROWS rows, per tile; optional abort
// input enabled by SA_TILE_CTRL_ABORT_EN.
module sa_tile_controller
    import sa_ctrl_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_MAX   = 16,
    parameter int TILE_W  = 8,
    parameter int CYCLE_W = 5
) (
    input logic clk,
    input logic rst,
    sa_tile_controller_if.slave bus
);

    localparam int KW        = $clog2(K_MAX + 1);
    localparam int DRAIN     = drain_len(ROWS, COLS);
    localparam int CYC_NEED  = (K_MAX > ROWS + COLS) ? K_MAX : ROWS + COLS;

    if ((2 ** CYCLE_W) <= CYC_NEED) begin : g_cycle_w_check
        $error("CYCLE_W too small for K_MAX / ROWS+COLS");
    end

    state_t              state_q, state_d;
    logic [KW-1:0]       k_len_q;
    logic [TILE_W-1:0]   num_tiles_q;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic                busy_q, done_q, cmd_err_q, cmd_err_d;
    logic                latch_cmd;
    logic                cnt_en;
    logic [CYCLE_W-1:0]  phase_len;
    logic [CYCLE_W-1:0]  count;
    logic                last;
    logic                cmd_legal;
    logic                abort_req;

`ifdef SA_TILE_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_legal = (bus.k_len != '0) && (int'(bus.k_len) <= K_MAX) && (bus.num_tiles != '0);

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        cmd_err_d = 1'b0;
        latch_cmd = 1'b0;
        cnt_en    = 1'b0;
        phase_len = CYCLE_W'(ROWS);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cmd_legal) begin
                        state_d   = S_LOAD_X;
                        tile_d    = '0;
                        latch_cmd = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_LOAD_X: begin
                cnt_en    = 1'b1;
                phase_len = CYCLE_W'(ROWS);
                if (last) state_d = S_MAC;
            end
            S_MAC: begin
                cnt_en    = 1'b1;
                phase_len = CYCLE_W'(k_len_q);
                if (last) state_d = (DRAIN == 0) ? S_STORE : S_DRAIN;
            end
            S_DRAIN: begin
                cnt_en    = 1'b1;
                phase_len = CYCLE_W'(DRAIN);
                if (last) state_d = S_STORE;
            end
            S_STORE: begin
                cnt_en    = bus.store_ready;
                phase_len = CYCLE_W'(ROWS);
                if (bus.store_ready && last) begin
                    if (tile_q == num_tiles_q - TILE_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_q + TILE_W'(1);
                        state_d = S_LOAD_X;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort outranks every phase transition, including a store beat on the same cycle.
        if (abort_req && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tile_d  = '0;
            cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            num_tiles_q <= '0;
            tile_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            cmd_err_q <= cmd_err_d;
            if (latch_cmd) begin
                k_len_q     <= bus.k_len;
                num_tiles_q <= bus.num_tiles;
            end
        end
    end

    sa_phase_counter #(.W(CYCLE_W)) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state_d != state_q),
        .en    (cnt_en),
        .len   (phase_len),
        .count (count),
        .last  (last)
    );

    assign bus.global_state = state_q;
    assign bus.cycle        = count;
    assign bus.tile_idx     = tile_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cmd_err      = cmd_err_q;
    assign bus.load_en      = (state_q == S_LOAD_X);
    assign bus.mac_en       = (state_q == S_MAC);
    assign bus.store_en     = (state_q == S_STORE) && bus.store_ready;

endmodule

// File: tb/tb_sa_tile_controller.sv
// Directed bench for sa_tile_controller (ROWS=4, COLS=4, K_MAX=16); abort case under SA_TILE_CTRL_ABORT_EN.
module tb_sa_tile_controller;
    localparam int ROWS = 4, COLS = 4, K_MAX = 16, TILE_W = 8, CYCLE_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sa_tile_controller_if #(.K_MAX(K_MAX), .TILE_W(TILE_W), .CYCLE_W(CYCLE_W)) bus ();

    sa_tile_controller #(
        .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .TILE_W(TILE_W), .CYCLE_W(CYCLE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(bus.global_state), 0);
        check({tag, "_cycle"}, 32'(bus.cycle), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_enables"}, {29'd0, bus.load_en, bus.mac_en, bus.store_en}, 0);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [4:0] k, input logic [7:0] n);
        bus.start     = 1'b1;
        bus.k_len     = k;
        bus.num_tiles = n;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic monitor(input int stall_len, output int done_at, output int busy_cnt,
                           output int done_cnt, output int load_entries, output int tile_err);
        int  n = 1;
        int  stall_left = 0;
        bit  stalled = 1'b0;
        int  exp_tile = 0;
        done_at = -1; busy_cnt = 0; done_cnt = 0; load_entries = 0; tile_err = 0;
        while (n < 300) begin
            if (bus.global_state == 3'd0 && !bus.busy && !bus.done) break;
            if (stall_len > 0 && !stalled && bus.global_state == 3'd4 && bus.cycle == 5'd2) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            bus.store_ready = (stall_left == 0);
            if (stall_left > 0) begin
                #1;
                check("stall_store_en", 32'(bus.store_en), 0);
                check("stall_cycle", 32'(bus.cycle), 2);
                stall_left--;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_at = n; end
            if (bus.global_state == 3'd1 && bus.cycle == 5'd0) begin
                if (int'(bus.tile_idx) != exp_tile) tile_err++;
                exp_tile++;
                load_entries++;
            end
            @(negedge clk);
            n++;
        end
        bus.store_ready = 1'b1;
        check("monitor_bound", 32'(n < 300), 1);
    endtask

    int done_at, busy_cnt, done_cnt, load_entries, tile_err;
    int ph_len[5] = '{4, 4, 6, 4, 1};
    bit ok;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.num_tiles = '0; bus.store_ready = 1'b1;
`ifdef SA_TILE_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_tile", 32'(bus.tile_idx), 0);
        check("reset_cmd_err", 32'(bus.cmd_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single tile, k_len=4: cycle-by-cycle state trace
        issue(5'd4, 8'd1);
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                check("t1_state", 32'(bus.global_state), 32'(p + 1));
                check("t1_cycle", 32'(bus.cycle), (p == 4) ? 0 : 32'(c));
                check("t1_busy", 32'(bus.busy), 1);
                check("t1_done", 32'(bus.done), (p == 4) ? 1 : 0);
                check("t1_enables", {29'd0, bus.load_en, bus.mac_en, bus.store_en},
                      (p == 0) ? 4 : (p == 1) ? 2 : (p == 3) ? 1 : 0);
                check("t1_tile", 32'(bus.tile_idx), 0);
                @(negedge clk);
            end
        end
        check_idle("t1_end");

        // Three tiles, k_len=2: 16 cycles per tile + done
        issue(5'd2, 8'd3);
        monitor(0, done_at, busy_cnt, done_cnt, load_entries, tile_err);
        check("t2_done_at", 32'(done_at), 49);
        check("t2_busy_cnt", 32'(busy_cnt), 49);
        check("t2_done_cnt", 32'(done_cnt), 1);
        check("t2_load_entries", 32'(load_entries), 3);
        check("t2_tile_seq_err", 32'(tile_err), 0);
        check("t2_last_tile", 32'(bus.tile_idx), 2);
        check_idle("t2_end");

        // Store backpressure: 3 stall cycles delay done by 3
        issue(5'd4, 8'd1);
        monitor(3, done_at, busy_cnt, done_cnt, load_entries, tile_err);
        check("t3_done_at", 32'(done_at), 22);
        check("t3_busy_cnt", 32'(busy_cnt), 22);
        check("t3_done_cnt", 32'(done_cnt), 1);

        // Illegal commands
        issue(5'd0, 8'd1);
        check("t4_k0_err", 32'(bus.cmd_err), 1);
        check_idle("t4_k0");
        @(negedge clk);
        check("t4_k0_pulse", 32'(bus.cmd_err), 0);
        issue(5'd17, 8'd1);
        check("t4_k17_err", 32'(bus.cmd_err), 1);
        check_idle("t4_k17");
        @(negedge clk);
        check("t4_k17_pulse", 32'(bus.cmd_err), 0);
        issue(5'd4, 8'd0);
        check("t4_n0_err", 32'(bus.cmd_err), 1);
        check_idle("t4_n0");
        @(negedge clk);
        check("t4_n0_pulse", 32'(bus.cmd_err), 0);
        check("t4_busy", 32'(bus.busy), 0);

        // Reset in S_MAC, then a normal run
        issue(5'd4, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.global_state == 3'd2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_reach_mac", 32'(ok), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("t5_rst");
        check("t5_rst_tile", 32'(bus.tile_idx), 0);
        check("t5_rst_cmd_err", 32'(bus.cmd_err), 0);
        rst = 1'b0;
        @(negedge clk);
        issue(5'd4, 8'd1);
        monitor(0, done_at, busy_cnt, done_cnt, load_entries, tile_err);
        check("t5_done_at", 32'(done_at), 19);
        check("t5_busy_cnt", 32'(busy_cnt), 19);

`ifdef SA_TILE_CTRL_ABORT_EN
        // Abort in S_DRAIN of the second tile
        issue(5'd2, 8'd2);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.global_state == 3'd3 && bus.tile_idx == 8'd1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("t6_reach_drain", 32'(ok), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("t6_abort");
        check("t6_tile", 32'(bus.tile_idx), 0);
        @(negedge clk);
        check("t6_no_done", 32'(bus.done), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
